conv_frame_sequencer: RTL and testbench
=======================================

// Module: conv_frame_sequencer
// PURPOSE
// - Frame-level scheduler for the conv layer.
// - Sits between the pixel FIFO read side and the conv/max_pool datapath.
// - Gates FIFO reads, tracks the raster (row, col) of each accepted pixel, and flags
//   which pixels complete a valid KxK window (MACC enable).
// - Stalls on downstream backpressure, drains the conv pipeline, and signals end of frame.
// PARAMETERS
// - IMG_W     32  input frame width, pixels
// - IMG_H     32  input frame height, pixels
// - K          5  conv kernel size (square)
// - PIPE_LAT   6  conv+pool pipeline depth, cycles from last MACC enable to last output
// - CW        $clog2(IMG_W)  column counter width (derived, localparam)
// - RW        $clog2(IMG_H)  row counter width (derived, localparam)
// PORTS
// - i_clk           in   1   system clock (clk200m domain)
// - i_rst_n         in   1   asynchronous active-low reset
// - i_start         in   1   one-cycle pulse: begin a new frame
// - i_abort         in   1   synchronous abort, returns to IDLE next cycle
// - i_pix_valid     in   1   pixel FIFO output valid
// - o_pix_ready     out  1   FIFO read enable; transfer = o_pix_ready & i_pix_valid
// - i_down_ready    in   1   max_pool/post-processing can accept conv outputs
// - o_macc_en       out  1   conv MACC enable (window complete on this pixel)
// - o_row           out  RW  row of last accepted pixel
// - o_col           out  CW  column of last accepted pixel
// - o_busy          out  1   high in FILL, RUN, DRAIN
// - o_frame_done    out  1   one-cycle pulse at end of frame
// - o_err_start     out  1   sticky: i_start seen while busy; cleared by next accepted i_start
// BEHAVIOUR
// - Reset (async, i_rst_n=0):
//   - all outputs 0; state IDLE; counters 0; drain counter 0.
// - States: IDLE -> FILL -> RUN -> DRAIN -> DONE -> IDLE.
// - IDLE:
//   - o_pix_ready=0.
//   - i_start=1 -> FILL; row/col counters cleared; o_err_start cleared.
// - FILL/RUN:
//   - o_pix_ready = i_down_ready (combinational, same cycle).
//   - On each transfer, col increments; at col=IMG_W-1, col wraps to 0 and row increments.
// - FILL -> RUN:
//   - on acceptance of pixel index (K-1)*IMG_W+(K-1), i.e. (row K-1, col K-1); 132 by default.
// - o_macc_en:
//   - registered, 1-cycle latency.
//   - High the cycle after a transfer whose (row, col) has row>=K-1 and col>=K-1.
//   - Low otherwise, including stall cycles.
// - o_row/o_col:
//   - registered alongside o_macc_en (same cycle); hold value while stalled.
// - RUN -> DRAIN:
//   - on acceptance of pixel (IMG_H-1, IMG_W-1); o_pix_ready=0 from next cycle.
// - DRAIN:
//   - count PIPE_LAT cycles after the last o_macc_en, then -> DONE.
//   - i_down_ready ignored.
// - DONE:
//   - o_frame_done=1 for exactly one cycle, then IDLE.
//   - i_start in DONE is honoured: it goes directly to FILL.
// - Output count per frame: (IMG_W-K+1)*(IMG_H-K+1) o_macc_en pulses; 784 by default.
// - i_start while busy:
//   - ignored for sequencing; sets o_err_start.
// - i_abort (any state but IDLE):
//   - IDLE next cycle; o_pix_ready, o_macc_en, o_busy deassert next cycle; no o_frame_done.
//   - i_abort has priority over i_start and over transfers in the same cycle; that pixel is not counted.
// - i_pix_valid=0 while ready:
//   - no count change; o_macc_en=0; no timeout.
// - Async reset mid-frame:
//   - immediate return to reset values; the FIFO is not flushed by this block.
// TESTING
// - Reset, i_start, stream 1024 pixels with i_pix_valid=i_down_ready=1
//   -> first o_macc_en the cycle after pixel 132 (row 4, col 4)
//   -> 784 o_macc_en pulses total
//   -> o_frame_done 1 cycle, PIPE_LAT+1 cycles after the last o_macc_en.
// - Drop i_down_ready for 10 cycles at pixel 500
//   -> o_pix_ready=0 and o_macc_en=0 for those 10 cycles
//   -> o_row/o_col held; total still 784 pulses, counts unchanged.
// - Random i_pix_valid gaps (50% duty)
//   -> o_macc_en only on transfers with row>=4, col>=4; col wraps 31->0 with row+1.
// - i_abort at pixel 300
//   -> IDLE next cycle, o_busy=0, no o_frame_done.
//   -> Fresh i_start then gives a full clean 784-pulse frame.
// - i_start at pixel 200 mid-frame
//   -> o_err_start=1 and held, frame continues unaffected.
//   -> Next i_start after o_frame_done clears it.
// - Assert i_rst_n=0 mid-RUN
//   -> all outputs 0 asynchronously (before next clock edge); state IDLE after release.

Source files
------------

// File: rtl/conv_frame_sequencer.sv
// conv_frame_sequencer
// Frame-level scheduler placed between the pixel FIFO read side and the
// conv/max_pool datapath. It gates FIFO reads, tracks the raster position of
// every accepted pixel, flags pixels that complete a KxK window (MACC enable),
// waits for the conv pipeline to drain and pulses end of frame.
//
// Ports
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_start         one-cycle pulse, begin a new frame
//   i_abort         synchronous abort back to IDLE
//   i_pix_valid     pixel FIFO output valid
//   o_pix_ready     FIFO read enable (transfer = o_pix_ready & i_pix_valid)
//   i_down_ready    downstream can accept conv outputs
//   o_macc_en       window complete on the last accepted pixel (1-cycle latency)
//   o_row, o_col    raster position of the last accepted pixel
//   o_busy          high in FILL, RUN, DRAIN
//   o_frame_done    one-cycle end-of-frame pulse
//   o_err_start     sticky: i_start arrived while busy
module conv_frame_sequencer #(
  parameter  int IMG_W    = 32,
  parameter  int IMG_H    = 32,
  parameter  int K        = 5,
  parameter  int PIPE_LAT = 6,
  localparam int CW       = $clog2(IMG_W),
  localparam int RW       = $clog2(IMG_H)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic          i_pix_valid,
  output logic          o_pix_ready,
  input  logic          i_down_ready,
  output logic          o_macc_en,
  output logic [RW-1:0] o_row,
  output logic [CW-1:0] o_col,
  output logic          o_busy,
  output logic          o_frame_done,
  output logic          o_err_start
);

  // Drain counter must hold the value PIPE_LAT (also valid for PIPE_LAT = 0).
  localparam int DW = $clog2(PIPE_LAT + 2);

  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);
  localparam logic [DW-1:0] DRAIN_END = DW'(PIPE_LAT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] row_q, row_d;         // position of the next pixel to accept
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] out_row_q, out_row_d; // position of the last accepted pixel
  logic [CW-1:0] out_col_q, out_col_d;
  logic          macc_q, macc_d;
  logic          err_q, err_d;
  logic [DW-1:0] drain_q, drain_d;

  logic streaming;
  logic busy;
  logic xfer;
  logic win_ok;
  logic fill_pix;
  logic last_pix;

  assign streaming = (state_q == S_FILL) || (state_q == S_RUN);
  assign busy      = streaming || (state_q == S_DRAIN);

  // Abort wins over a simultaneous transfer: that pixel is not counted.
  assign o_pix_ready = streaming & i_down_ready;
  assign xfer        = o_pix_ready & i_pix_valid & ~i_abort;

  assign win_ok   = (row_q >= ROW_FIRST) && (col_q >= COL_FIRST);
  assign fill_pix = (row_q == ROW_FIRST) && (col_q == COL_FIRST);
  assign last_pix = (row_q == ROW_LAST)  && (col_q == COL_LAST);

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    out_row_d = out_row_q;
    out_col_d = out_col_q;
    macc_d    = 1'b0;
    err_d     = err_q;
    drain_d   = drain_q;

    if (i_start && busy) begin
      err_d = 1'b1;
    end

    if (xfer) begin
      out_row_d = row_q;
      out_col_d = col_q;
      macc_d    = win_ok;
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    if (i_abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          // DONE always falls back to IDLE unless a new frame starts at once.
          state_d = S_IDLE;
          if (i_start) begin
            state_d   = S_FILL;
            row_d     = '0;
            col_d     = '0;
            out_row_d = '0;
            out_col_d = '0;
            err_d     = 1'b0;
          end
        end
        S_FILL: begin
          if (xfer && fill_pix) state_d = S_RUN;
        end
        S_RUN: begin
          if (xfer && last_pix) begin
            state_d = S_DRAIN;
            drain_d = '0;
          end
        end
        S_DRAIN: begin
          // The first DRAIN cycle is the one showing the last MACC enable.
          if (drain_q == DRAIN_END) begin
            state_d = S_DONE;
          end else begin
            drain_d = drain_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      out_row_q <= '0;
      out_col_q <= '0;
      macc_q    <= 1'b0;
      err_q     <= 1'b0;
      drain_q   <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      out_row_q <= out_row_d;
      out_col_q <= out_col_d;
      macc_q    <= macc_d;
      err_q     <= err_d;
      drain_q   <= drain_d;
    end
  end

  assign o_macc_en    = macc_q;
  assign o_row        = out_row_q;
  assign o_col        = out_col_q;
  assign o_busy       = busy;
  assign o_frame_done = (state_q == S_DONE);
  assign o_err_start  = err_q;

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// tb_conv_frame_sequencer
// Directed bench for conv_frame_sequencer with default parameters
// (32x32 frame, K=5, PIPE_LAT=6). A negedge monitor predicts o_macc_en,
// o_row/o_col and o_pix_ready from the raster index of each accepted pixel.
module tb_conv_frame_sequencer;

  localparam int W     = 32;
  localparam int H     = 32;
  localparam int KK    = 5;
  localparam int NPIX  = W * H;
  localparam int NMACC = (W - KK + 1) * (H - KK + 1);

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_start, i_abort, i_pix_valid, i_down_ready;
  logic       o_pix_ready, o_macc_en, o_busy, o_frame_done, o_err_start;
  logic [4:0] o_row;
  logic [4:0] o_col;

  always #5 clk = ~clk;

  conv_frame_sequencer dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .i_pix_valid  (i_pix_valid),
    .o_pix_ready  (o_pix_ready),
    .i_down_ready (i_down_ready),
    .o_macc_en    (o_macc_en),
    .o_row        (o_row),
    .o_col        (o_col),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done),
    .o_err_start  (o_err_start)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Control flags written by the stimulus, read by the monitor.
  logic mon_en    = 1'b0;
  logic mon_clear = 1'b0;
  logic in_frame  = 1'b0;

  // Monitor-owned statistics.
  int   cyc = 0;
  int   pix_cnt = 0;
  int   macc_cnt = 0;
  int   done_cnt = 0;
  int   err_macc = 0;
  int   err_pos = 0;
  int   err_ready = 0;
  int   last_macc_cyc = 0;
  int   done_cyc = 0;
  int   first_pix = 0;
  int   first_row = 0;
  int   first_col = 0;
  logic exp_macc = 1'b0;
  logic exp_pos_valid = 1'b0;
  int   exp_row = 0;
  int   exp_col = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_clear) begin
      pix_cnt       <= 0;
      macc_cnt      <= 0;
      done_cnt      <= 0;
      err_macc      <= 0;
      err_pos       <= 0;
      err_ready     <= 0;
      exp_macc      <= 1'b0;
      exp_pos_valid <= 1'b0;
    end else if (mon_en) begin
      if (o_macc_en !== exp_macc) err_macc <= err_macc + 1;
      if (exp_pos_valid && (int'(o_row) != exp_row || int'(o_col) != exp_col))
        err_pos <= err_pos + 1;
      if (o_pix_ready !== ((in_frame && pix_cnt < NPIX) ? i_down_ready : 1'b0))
        err_ready <= err_ready + 1;
      if (o_macc_en === 1'b1) begin
        macc_cnt      <= macc_cnt + 1;
        last_macc_cyc <= cyc;
        if (macc_cnt == 0) begin
          first_pix <= pix_cnt;
          first_row <= int'(o_row);
          first_col <= int'(o_col);
        end
      end
      if (o_frame_done === 1'b1) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      if (i_pix_valid && o_pix_ready && !i_abort) begin
        exp_macc      <= ((pix_cnt / W) >= KK - 1) && ((pix_cnt % W) >= KK - 1);
        exp_row       <= pix_cnt / W;
        exp_col       <= pix_cnt % W;
        exp_pos_valid <= 1'b1;
        pix_cnt       <= pix_cnt + 1;
      end else begin
        exp_macc <= 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_frame();
    mon_clear = 1'b1;
    i_start   = 1'b1;
    tick();
    i_start   = 1'b0;
    mon_clear = 1'b0;
    in_frame  = 1'b1;
  endtask

  task automatic wait_done(input string name);
    int guard;
    guard = 0;
    i_pix_valid  = 1'b0;
    i_down_ready = 1'b1;
    while (done_cnt == 0 && guard < 50) begin
      tick();
      guard++;
    end
    tick();
    tick();
    check({name, ":done_pulses"}, done_cnt, 1);
    check({name, ":done_gap"}, done_cyc - last_macc_cyc, 7);
    check({name, ":busy_after"}, int'(o_busy), 0);
  endtask

  task automatic run_frame(input string name, input int stall_at, input bit rand_valid,
                           input int abort_at, input int err_at);
    int  guard;
    int  stall_left;
    bit  stalled;
    bit  err_pending;
    bit  aborted;
    guard = 0; stall_left = 0; stalled = 0; err_pending = 0; aborted = 0;
    begin_frame();
    while (pix_cnt < NPIX && guard < 20000) begin
      guard++;
      if (err_pending) begin
        check({name, ":err_start_set"}, int'(o_err_start), 1);
        err_pending = 0;
      end
      i_start      = 1'b0;
      i_pix_valid  = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      i_down_ready = 1'b1;
      if (stall_at >= 0 && pix_cnt == stall_at && !stalled) begin
        stalled    = 1;
        stall_left = 10;
      end
      if (stall_left > 0) begin
        i_down_ready = 1'b0;
        stall_left--;
        if (stall_left == 0) begin
          #1;
          // Pixel 499 is (row 15, col 19).
          check({name, ":stall_ready"}, int'(o_pix_ready), 0);
          check({name, ":stall_macc"}, int'(o_macc_en), 0);
          check({name, ":stall_row"}, int'(o_row), 15);
          check({name, ":stall_col"}, int'(o_col), 19);
        end
      end
      if (err_at >= 0 && pix_cnt == err_at && !err_pending && guard < 20000) begin
        if (!stalled || stall_left == 0) begin
          i_start     = 1'b1;
          err_pending = 1;
          err_at      = -1;
        end
      end
      if (abort_at >= 0 && pix_cnt == abort_at) begin
        i_abort = 1'b1;
        tick();
        i_abort  = 1'b0;
        in_frame = 1'b0;
        aborted  = 1;
        break;
      end
      tick();
    end
    i_start = 1'b0;
    if (aborted) begin
      check({name, ":abort_busy"}, int'(o_busy), 0);
      check({name, ":abort_ready"}, int'(o_pix_ready), 0);
      check({name, ":abort_macc"}, int'(o_macc_en), 0);
      repeat (20) tick();
      // Pixels 0..299: rows 4..8 give 5*28, row 9 cols 4..11 give 8.
      check({name, ":abort_pulses"}, macc_cnt, 148);
      check({name, ":abort_no_done"}, done_cnt, 0);
      check({name, ":abort_busy_late"}, int'(o_busy), 0);
      $display("%s: aborted after %0d pixels, %0d MACC pulses", name, pix_cnt, macc_cnt);
    end else begin
      check({name, ":pixels"}, pix_cnt, NPIX);
      wait_done(name);
      check({name, ":pulses"}, macc_cnt, NMACC);
      check({name, ":macc_model"}, err_macc, 0);
      check({name, ":pos_model"}, err_pos, 0);
      check({name, ":ready_model"}, err_ready, 0);
      $display("%s: %0d pixels, %0d MACC pulses, %0d done pulses", name, pix_cnt, macc_cnt, done_cnt);
    end
  endtask

  initial begin
    int guard;
    rst_n        = 1'b0;
    i_start      = 1'b0;
    i_abort      = 1'b0;
    i_pix_valid  = 1'b0;
    i_down_ready = 1'b0;
    repeat (3) tick();
    check("rst_busy", int'(o_busy), 0);
    check("rst_ready", int'(o_pix_ready), 0);
    check("rst_macc", int'(o_macc_en), 0);
    check("rst_row", int'(o_row), 0);
    check("rst_col", int'(o_col), 0);
    check("rst_done", int'(o_frame_done), 0);
    check("rst_err", int'(o_err_start), 0);
    rst_n = 1'b1;
    tick();
    mon_en = 1'b1;
    tick();

    run_frame("clean", -1, 1'b0, -1, -1);
    check("clean:first_pix_cnt", first_pix, 133);
    check("clean:first_row", first_row, 4);
    check("clean:first_col", first_col, 4);
    repeat (2) tick();

    run_frame("stall", 500, 1'b0, -1, -1);
    repeat (2) tick();

    run_frame("gaps", -1, 1'b1, -1, -1);
    repeat (2) tick();

    run_frame("abort", -1, 1'b0, 300, -1);
    repeat (2) tick();

    run_frame("after_abort", -1, 1'b0, -1, -1);
    repeat (2) tick();

    run_frame("err_start", -1, 1'b0, -1, 200);
    check("err_start:held", int'(o_err_start), 1);
    repeat (2) tick();

    // New frame clears the sticky error, then reset hits mid-RUN.
    begin_frame();
    check("restart:err_cleared", int'(o_err_start), 0);
    i_pix_valid  = 1'b1;
    i_down_ready = 1'b1;
    guard = 0;
    while (pix_cnt < 400 && guard < 2000) begin
      tick();
      guard++;
    end
    check("midrun:pixels", pix_cnt, 400);
    // Pixel 399 is (row 12, col 15): window complete.
    check("midrun:macc_before", int'(o_macc_en), 1);
    check("midrun:busy_before", int'(o_busy), 1);
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst:busy", int'(o_busy), 0);
    check("async_rst:ready", int'(o_pix_ready), 0);
    check("async_rst:macc", int'(o_macc_en), 0);
    check("async_rst:row", int'(o_row), 0);
    check("async_rst:col", int'(o_col), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("post_rst:busy", int'(o_busy), 0);
    check("post_rst:ready", int'(o_pix_ready), 0);
    $display("reset mid-run: outputs cleared, sequencer idle");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
